// File: rtl/fir_tone_pkg.sv
// Shared constants, quadrant type and quarter-wave table generator for the
// DDS tone source that drives the FIR stage input.
package fir_tone_pkg;

    localparam int PHASE_W   = 32;
    localparam int LUT_AW    = 8;
    localparam int DATA_W    = 24;
    localparam int ROM_DEPTH = 1 << LUT_AW;
    localparam int ROM_W     = DATA_W - 1;
    localparam int AMP_W     = 16;
    localparam int AMP_FRAC  = 15;
    localparam int PROD_W    = DATA_W + AMP_W + 1;

    localparam int          SAMPLE_MAX = 8388607;
    localparam logic [15:0] AMP_UNITY  = 16'h8000;

    localparam real PI = 3.14159265358979323846;

    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quad_t;

    // Entries sit at half-step offsets so neither zero nor full scale is stored.
    function automatic logic [ROM_W-1:0] quarter_sine(input int k);
        real angle;
        real value;
        angle = PI / 2.0 * (real'(k) + 0.5) / real'(ROM_DEPTH);
        value = real'(SAMPLE_MAX) * $sin(angle);
        return ROM_W'($rtoi(value + 0.5));
    endfunction

    function automatic logic [LUT_AW-1:0] mirror_addr(input quad_t quad,
                                                      input logic [LUT_AW-1:0] idx);
        return (quad == QUAD_1 || quad == QUAD_3) ? ~idx : idx;
    endfunction

    function automatic logic is_lower_half(input quad_t quad);
        return (quad == QUAD_2 || quad == QUAD_3);
    endfunction

endpackage

// File: rtl/fir_tone_gen_if.sv
// Control and sample bundle between the stimulus controller and the tone
// generator; the sample side lands on the FIR inputData port.
interface fir_tone_gen_if;
    import fir_tone_pkg::*;

    logic               enable;
    logic               ftwLoad;
    logic [PHASE_W-1:0] ftwIn;
    logic               phaseClear;
    logic [AMP_W-1:0]   amp;
    logic [DATA_W-1:0]  sampleOut;
    logic               sampleValid;

    modport master (
        output enable,
        output ftwLoad,
        output ftwIn,
        output phaseClear,
        output amp,
        input  sampleOut,
        input  sampleValid
    );

    modport slave (
        input  enable,
        input  ftwLoad,
        input  ftwIn,
        input  phaseClear,
        input  amp,
        output sampleOut,
        output sampleValid
    );

endinterface

// File: rtl/fir_tone_gen_rom.sv
// Quarter-wave sine table: 256 x 23-bit unsigned magnitudes, synchronous
// read with a registered output so it maps onto a block RAM.
module quarter_sine_rom
    import fir_tone_pkg::*;
(
    input  logic              clk,
    input  logic [LUT_AW-1:0] addr_i,
    output logic [ROM_W-1:0]  data_o
);

    logic [ROM_W-1:0] rom_tab [ROM_DEPTH];
    logic [ROM_W-1:0] data_q;

    for (genvar k = 0; k < ROM_DEPTH; k++) begin : g_entry
        localparam logic [ROM_W-1:0] ENTRY = quarter_sine(k);
        assign rom_tab[k] = ENTRY;
    end

    // NOTE: the read register has no reset so it can use the block RAM output
    // latch; downstream valid gating makes its power-up contents irrelevant.
    always_ff @(posedge clk) begin
        data_q <= rom_tab[addr_i];
    end

    assign data_o = data_q;

endmodule

// File: rtl/fir_tone_gen.sv
// DDS tone generator: phase accumulator, mirrored quarter-wave lookup and a
// negate/scale/saturate stage, three register stages from enable to sample.
module fir_tone_gen
    import fir_tone_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    fir_tone_gen_if.slave tone
);

    localparam logic signed [PROD_W-1:0] SAT_HI = PROD_W'(SAMPLE_MAX);
    localparam logic signed [PROD_W-1:0] SAT_LO = -SAT_HI;

    logic [PHASE_W-1:0]       ftw_q, ftw_d;
    logic [PHASE_W-1:0]       phase_q, phase_d;
    quad_t                    s0_quad_q, s0_quad_d;
    logic [LUT_AW-1:0]        s0_idx_q, s0_idx_d;
    logic                     s0_valid_q, s0_valid_d;
    quad_t                    s1_quad_q, s1_quad_d;
    logic                     s1_valid_q, s1_valid_d;
    logic signed [DATA_W-1:0] sample_q, sample_d;
    logic                     valid_q, valid_d;

    logic [LUT_AW-1:0]        rom_addr;
    logic [ROM_W-1:0]         rom_data;
    logic signed [DATA_W-1:0] signed_val;
    logic signed [PROD_W-1:0] product;
    logic signed [PROD_W-1:0] scaled;
    logic signed [DATA_W-1:0] limited;

    quarter_sine_rom u_rom (
        .clk    (clk),
        .addr_i (rom_addr),
        .data_o (rom_data)
    );

    // NOTE: every signal gets a default first so no path through the
    // conditionals leaves a value unassigned, which would infer a latch.
    always_comb begin
        ftw_d      = ftw_q;
        phase_d    = phase_q;
        s0_quad_d  = quad_t'(phase_q[PHASE_W-1 -: 2]);
        s0_idx_d   = phase_q[PHASE_W-3 -: LUT_AW];
        s0_valid_d = tone.enable;
        s1_quad_d  = s0_quad_q;
        s1_valid_d = s0_valid_q;
        sample_d   = sample_q;
        valid_d    = s1_valid_q;

        if (tone.ftwLoad) begin
            ftw_d = tone.ftwIn;
        end

        // Clear beats enable; accumulation always uses the word already held.
        if (tone.phaseClear) begin
            phase_d = '0;
        end else if (tone.enable) begin
            phase_d = phase_q + ftw_q;
        end

        rom_addr = mirror_addr(s0_quad_q, s0_idx_q);

        signed_val = $signed({1'b0, rom_data});
        if (is_lower_half(s1_quad_q)) begin
            signed_val = -signed_val;
        end

        // Arithmetic shift floors toward minus infinity; clamp is symmetric.
        product = PROD_W'(signed_val) * PROD_W'($signed({1'b0, tone.amp}));
        scaled  = product >>> AMP_FRAC;
        limited = scaled[DATA_W-1:0];
        if (scaled > SAT_HI) begin
            limited = DATA_W'(SAT_HI);
        end else if (scaled < SAT_LO) begin
            limited = DATA_W'(SAT_LO);
        end

        if (s1_valid_q) begin
            sample_d = limited;
        end
    end

    // NOTE: state registers use non-blocking assignments so every stage
    // samples the pre-edge value of the stage before it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ftw_q      <= '0;
            phase_q    <= '0;
            s0_quad_q  <= QUAD_0;
            s0_idx_q   <= '0;
            s0_valid_q <= 1'b0;
            s1_quad_q  <= QUAD_0;
            s1_valid_q <= 1'b0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
        end else begin
            ftw_q      <= ftw_d;
            phase_q    <= phase_d;
            s0_quad_q  <= s0_quad_d;
            s0_idx_q   <= s0_idx_d;
            s0_valid_q <= s0_valid_d;
            s1_quad_q  <= s1_quad_d;
            s1_valid_q <= s1_valid_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
        end
    end

    assign tone.sampleOut   = sample_q;
    assign tone.sampleValid = valid_q;

    sample_in_range: assert property (@(posedge clk) disable iff (!reset)
        valid_q |-> (sample_q <= DATA_W'(SAT_HI) && sample_q >= DATA_W'(SAT_LO)));

endmodule

// File: tb/tb_fir_tone_gen.sv
// Bench for fir_tone_gen: directed vector table, mid-cycle reset sequence and
// a randomized run against an arithmetic reference model.
module tb_fir_tone_gen;

    localparam real         PI_R  = 3.14159265358979323846;
    localparam int          FULL  = 8388607;
    localparam int          S0    = 25736;
    localparam int          SP    = 8388568;
    localparam logic [15:0] U     = 16'h8000;
    localparam logic [15:0] F     = 16'hFFFF;
    localparam logic [31:0] W     = 32'h4000_0000;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    fir_tone_gen_if tone ();

    fir_tone_gen dut (
        .clk   (clk),
        .reset (reset),
        .tone  (tone)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        en;
        logic        ld;
        logic [31:0] ftw_in;
        logic        clr;
        logic [15:0] amp;
        logic        exp_v;
        int          exp_s;
    } vec_t;

    typedef struct {
        logic en;
        int   val;
    } issue_t;

    vec_t        tbl [$];
    logic [31:0] m_phase;
    logic [31:0] m_ftw;
    int          m_sample;
    issue_t      m_pipe [$];

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic en, input logic ld, input logic [31:0] f,
                                input logic clr, input logic [15:0] a,
                                input logic ev, input int es);
        vec_t v;
        v.en = en; v.ld = ld; v.ftw_in = f; v.clr = clr; v.amp = a;
        v.exp_v = ev; v.exp_s = es;
        return v;
    endfunction

    task automatic drive(input logic en, input logic ld, input logic [31:0] f,
                         input logic clr, input logic [15:0] a);
        tone.enable     = en;
        tone.ftwLoad    = ld;
        tone.ftwIn      = f;
        tone.phaseClear = clr;
        tone.amp        = a;
    endtask

    // Sine of the quarter-wave point selected by the phase, signed by half-cycle.
    function automatic int sine_of(input logic [31:0] ph);
        int  quad, idx, k, mag;
        real ang;
        quad = int'(ph[31:30]);
        idx  = int'(ph[29:22]);
        k    = (quad % 2 == 1) ? 255 - idx : idx;
        ang  = PI_R / 2.0 * (real'(k) + 0.5) / 256.0;
        mag  = $rtoi(real'(FULL) * $sin(ang) + 0.5);
        return (quad >= 2) ? -mag : mag;
    endfunction

    function automatic int scale(input int v, input int a);
        longint p, q;
        p = longint'(v) * longint'(a);
        if (p >= 0) q = p / 32768;
        else        q = -((-p + 32767) / 32768);
        if (q > FULL)  q = FULL;
        if (q < -FULL) q = -FULL;
        return int'(q);
    endfunction

    task automatic model_reset();
        issue_t idle;
        idle.en  = 1'b0;
        idle.val = 0;
        m_phase  = '0;
        m_ftw    = '0;
        m_sample = 0;
        m_pipe   = {};
        m_pipe.push_back(idle);
        m_pipe.push_back(idle);
    endtask

    task automatic model_step(input logic en, input logic ld, input logic [31:0] f,
                              input logic clr, input logic [15:0] a,
                              output logic ev, output int es);
        issue_t cur, done;
        cur.en  = en;
        cur.val = sine_of(m_phase);
        done    = m_pipe.pop_front();
        m_pipe.push_back(cur);
        if (done.en) m_sample = scale(done.val, int'(a));
        ev = done.en;
        es = m_sample;
        if (clr)     m_phase = '0;
        else if (en) m_phase = m_phase + m_ftw;
        if (ld)      m_ftw = f;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic        ev;
        int          es;
        int          rise;
        logic        r_en, r_ld, r_clr;
        logic [31:0] r_f;
        logic [15:0] r_a;

        drive(1'b0, 1'b0, '0, 1'b0, U);

        // Reset-state and startup rows, quadrant walk, saturation, enable gaps,
        // clear priority, delayed tuning word, wrap-around.
        tbl.push_back(mk(1, 0, 0, 0, U, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, U, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, U, 1, S0));
        tbl.push_back(mk(1, 0, 0, 0, U, 1, S0));
        tbl.push_back(mk(1, 1, W, 0, U, 1, S0));
        tbl.push_back(mk(1, 0, 0, 0, U, 1, S0));
        tbl.push_back(mk(1, 0, 0, 0, U, 1, S0));
        tbl.push_back(mk(1, 0, 0, 0, U, 1, S0));
        tbl.push_back(mk(1, 0, 0, 0, U, 1, SP));
        tbl.push_back(mk(1, 0, 0, 0, U, 1, -S0));
        tbl.push_back(mk(1, 0, 0, 0, U, 1, -SP));
        tbl.push_back(mk(1, 0, 0, 0, U, 1, S0));
        tbl.push_back(mk(1, 0, 0, 0, F, 1, FULL));
        tbl.push_back(mk(1, 0, 0, 0, F, 1, -51472));
        tbl.push_back(mk(1, 0, 0, 0, F, 1, -FULL));
        tbl.push_back(mk(1, 0, 0, 0, F, 1, 51471));
        tbl.push_back(mk(1, 0, 0, 0, U, 1, SP));
        tbl.push_back(mk(1, 0, 0, 0, U, 1, -S0));
        tbl.push_back(mk(0, 0, 0, 0, U, 1, -SP));
        tbl.push_back(mk(0, 0, 0, 0, U, 1, S0));
        tbl.push_back(mk(1, 0, 0, 0, U, 0, S0));
        tbl.push_back(mk(1, 0, 0, 0, U, 0, S0));
        tbl.push_back(mk(1, 0, 0, 0, U, 1, SP));
        tbl.push_back(mk(0, 0, 0, 0, U, 1, -S0));
        tbl.push_back(mk(0, 0, 0, 0, U, 1, -SP));
        tbl.push_back(mk(0, 0, 0, 0, U, 0, -SP));
        tbl.push_back(mk(1, 0, 0, 0, U, 0, -SP));
        tbl.push_back(mk(1, 0, 0, 1, U, 0, -SP));
        tbl.push_back(mk(1, 0, 0, 0, U, 1, S0));
        tbl.push_back(mk(1, 0, 0, 0, U, 1, SP));
        tbl.push_back(mk(1, 0, 0, 0, U, 1, S0));
        tbl.push_back(mk(1, 1, 32'h8000_0000, 0, U, 1, SP));
        tbl.push_back(mk(1, 0, 0, 0, U, 1, -S0));
        tbl.push_back(mk(1, 0, 0, 0, U, 1, -SP));
        tbl.push_back(mk(1, 0, 0, 0, U, 1, S0));
        tbl.push_back(mk(1, 0, 0, 0, U, 1, -S0));
        tbl.push_back(mk(1, 1, 32'hFFFF_FFFF, 1, U, 1, S0));
        tbl.push_back(mk(1, 0, 0, 0, U, 1, -S0));
        tbl.push_back(mk(1, 0, 0, 0, U, 1, S0));
        tbl.push_back(mk(1, 0, 0, 0, U, 1, S0));
        tbl.push_back(mk(1, 0, 0, 0, U, 1, -S0));
        tbl.push_back(mk(1, 0, 0, 0, U, 1, -S0));

        #2 reset = 1'b0;
        #1;
        check("reset_sample", 32'($signed(tone.sampleOut)), 0);
        check("reset_valid", 32'(tone.sampleValid), 0);
        @(negedge clk);
        reset = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].ld, tbl[i].ftw_in, tbl[i].clr, tbl[i].amp);
            @(posedge clk);
            #1;
            check($sformatf("row%0d_valid", i + 1), 32'(tone.sampleValid), 32'(tbl[i].exp_v));
            check($sformatf("row%0d_sample", i + 1), 32'($signed(tone.sampleOut)), tbl[i].exp_s);
        end

        // Asynchronous reset in the middle of a cycle while streaming.
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("midreset_sample", 32'($signed(tone.sampleOut)), 0);
        check("midreset_valid", 32'(tone.sampleValid), 0);
        drive(1'b1, 1'b0, '0, 1'b0, U);
        @(negedge clk);
        reset = 1'b1;
        rise = -1;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            #1;
            if (tone.sampleValid === 1'b1) begin
                rise = e;
                break;
            end
        end
        check("midreset_rise_edges", rise, 3);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("midreset_const%0d", c), 32'($signed(tone.sampleOut)), S0);
            check($sformatf("midreset_valid%0d", c), 32'(tone.sampleValid), 1);
            @(posedge clk);
            #1;
        end

        // Randomized run against the reference model from a fresh reset.
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0, U);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            r_en  = ($urandom_range(0, 9) < 8);
            r_ld  = ($urandom_range(0, 15) == 0);
            r_clr = ($urandom_range(0, 31) == 0);
            case ($urandom_range(0, 3))
                0:       r_f = $urandom;
                1:       r_f = 32'($urandom_range(0, 4096)) << $urandom_range(0, 20);
                2:       r_f = W;
                default: r_f = 32'hFFFF_FFFF;
            endcase
            case ($urandom_range(0, 3))
                0:       r_a = 16'($urandom);
                1:       r_a = F;
                2:       r_a = U;
                default: r_a = 16'($urandom_range(0, 255));
            endcase
            drive(r_en, r_ld, r_f, r_clr, r_a);
            model_step(r_en, r_ld, r_f, r_clr, r_a, ev, es);
            @(posedge clk);
            #1;
            check($sformatf("rand%0d_valid", i), 32'(tone.sampleValid), 32'(ev));
            check($sformatf("rand%0d_sample", i), 32'($signed(tone.sampleOut)), es);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fir_tone_gen.md
# fir_tone_gen

- Direct digital synthesis (DDS) tone generator.
- Sits directly upstream of the FIR filter stage and drives its 24-bit signed `inputData` with a sine sample stream.
- Used for in-system stimulus and passband/stopband checks.
- Built from a 32-bit phase accumulator, a quarter-wave sine ROM, quadrant mirroring and a Q1.15 amplitude scaler, in a 3-stage pipeline.

## Interface
Parameters:
- `PHASE_W`, 32: phase accumulator width.
- `LUT_AW`, 8: quarter-wave ROM address width (256 entries).
- `DATA_W`, 24: output sample width, signed.

Ports:
- `clk`  in  1: sole clock.
- `reset`  in  1: asynchronous, active-low reset.
- `enable`  in  1: advance the phase and issue a sample this cycle.
- `ftwLoad`  in  1: load `ftwIn` into the active tuning word.
- `ftwIn`  in  PHASE_W: frequency tuning word (unsigned).
- `phaseClear`  in  1: synchronous zeroing of the phase accumulator.
- `amp`  in  16: unsigned Q1.15 gain; 0x8000 = unity.
- `sampleOut`  out  DATA_W: signed sample; connects to the FIR `inputData`.
- `sampleValid`  out  1: `sampleOut` carries a new sample.

## Operation
- **Tuning word:** `ftwLoad` high → `ftw` <= `ftwIn`; the new value is used from the next accumulation onward.
- **Phase accumulator (S0):**
  - `phaseClear` → `phase` <= 0.
  - else if `enable` → `phase` <= `phase` + `ftw`, modulo 2^PHASE_W (wrap-around is intended).
  - else `phase` holds.
  - `phaseClear` wins over `enable` on the same cycle.
  - `ftwLoad` together with `enable`: the accumulation that cycle uses the old `ftw`.
- **Stage 1:**
  - `quad` = `phase`[31:30].
  - `idx` = `phase`[29:22].
  - Address = `idx` for quadrants 0 and 2; ~`idx` for quadrants 1 and 3.
  - ROM output is registered; `quad` is registered alongside it.
- **ROM contents:** entry k = round(8388607·sin(π/2·(k+0.5)/256)).
  - Entry 0 = 25736; entry 255 = 8388568.
  - No entry is 0 or full scale.
- **Stage 2:**
  - Quadrants 2 and 3 negate the ROM value.
  - Signed result × {1'b0, `amp`} gives a 41-bit product, arithmetic-shifted right by 15 (truncation toward −∞).
  - Saturate to ±8388607 (symmetric; −8388608 is never produced).
  - `amp` is sampled at the edge on which stage 2 registers.
- **Valid / hold:**
  - `sampleValid` is `enable` delayed through the 3 stages.
  - `sampleOut` updates only when its delayed-valid is set; otherwise it holds the last value.

## Timing
- **Latency:** `enable` sampled high at edge n → `sampleValid` = 1 and `sampleOut` = sine(phase before edge n) after edge n+2.
  - Effectively 3 register stages including the accumulator.
- **Throughput:** one sample per clock while `enable` is high. No backpressure; the FIR consumes every cycle.
- **Reset (async, `reset` = 0):** `phase` = 0, `ftw` = 0, all pipeline registers = 0, `sampleOut` = 0, `sampleValid` = 0.
- **Reset mid-stream:** in-flight samples are discarded.
- **After reset release:** the first valid sample is ROM[0] × `amp` (phase 0), even if `ftw` = 0.
- **`ftw` = 0 with `enable` high:** a constant sample stream, valid every cycle.
- **`enable` low:** the pipeline drains. `sampleValid` drops 3 cycles after `enable` drops; `sampleOut` holds.

## Structure
- **Package `fir_tone_pkg`:**
  - PHASE_W, LUT_AW, DATA_W.
  - SAMPLE_MAX = 8388607.
  - AMP_UNITY = 16'h8000.
  - The quarter-sine ROM constant array (or its generating function) and the quadrant type.
- **Sub-module `quarter_sine_rom`:**
  - Synchronous-read, 256×23-bit unsigned ROM initialised from the package.
  - Single address in, registered data out.
  - Maps to block RAM.
- **Top:** accumulator, address mirroring, negate/scale/saturate and valid pipeline.

## Test plan
- **Reset:** assert `reset` = 0 asynchronously mid-cycle while enabled.
  - Required: `sampleOut` = 0 and `sampleValid` = 0 immediately.
  - After release with `enable` = 1, `ftw` = 0, `amp` = 0x8000: `sampleValid` rises after 3 edges, and `sampleOut` = 25736 constant.
- **Quadrant walk:** `ftwLoad` with `ftwIn` = 0x40000000, `amp` = 0x8000, `enable` = 1.
  - Required repeating output: 25736, 8388568, −25736, −8388568.
- **Saturation and truncation:** same tuning, `amp` = 0xFFFF.
  - Required output: 51471, 8388607, −51472, −8388607.
- **Clear priority and tuning-word timing:**
  - `phaseClear` and `enable` high together → the next phase is 0.
  - `ftwLoad` during `enable` → the old word is used one more accumulation, visible as the output sequence shifted by one sample.
- **Enable gaps:** toggle `enable` 1,0,0,1 at `ftw` = 0x40000000.
  - Required: `sampleValid` mirrors the pattern 3 cycles later, `sampleOut` holds during the gap, and the phase sequence continues without skipping.
- **Wrap-around:** `ftw` = 0xFFFFFFFF from phase 0.
  - Required: the phase wraps to 0xFFFFFFFF, quadrant 3 with mirrored `idx` 255 → ROM[0] → `sampleOut` = −25736, with no glitch at the wrap.
